// File: rtl/frame_strobe_sequencer.sv
// ---------------------------------------------------------------------------
// frame_strobe_sequencer
//
// Per-column frame-strobe sequencer on the eFPGA configuration path. It takes
// frame-write requests from the shared config bus and drives the matching
// one-hot frame strobe. Each strobe is preceded by programmable setup cycles
// and followed by programmable hold cycles. One instance sits in each fabric
// column.
//
// Ports:
//   CLK           in   configuration clock
//   resetn        in   asynchronous active-low reset
//   ReqValid      in   request valid
//   ReqReady      out  high while IDLE; a request is taken on ReqValid&&ReqReady
//   FrameSelect   in   column select of the request (FrameSelectWidth)
//   FrameIndex    in   frame number within the column (FrameIndexWidth)
//   FrameStrobe_O out  registered one-hot strobe to the frame latches
//   Busy          out  high while a matched request is in flight
//   Done          out  one-cycle pulse in the first IDLE cycle after a request
//   ErrIndex      out  one-cycle pulse for a matched request with a bad index
// ---------------------------------------------------------------------------
module frame_strobe_sequencer #(
    parameter int MaxFramesPerCol  = 20,
    parameter int FrameSelectWidth = 5,
    parameter int FrameIndexWidth  = 5,
    parameter int Col              = 18,
    parameter bit BroadcastEn      = 1'b1,
    parameter int BroadcastSel     = 31,
    parameter int SetupCycles      = 1,
    parameter int StrobeCycles     = 2,
    parameter int HoldCycles       = 1
) (
    input  logic                        CLK,
    input  logic                        resetn,
    input  logic                        ReqValid,
    output logic                        ReqReady,
    input  logic [FrameSelectWidth-1:0] FrameSelect,
    input  logic [FrameIndexWidth-1:0]  FrameIndex,
    output logic [MaxFramesPerCol-1:0]  FrameStrobe_O,
    output logic                        Busy,
    output logic                        Done,
    output logic                        ErrIndex
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Each timed state loads (N-1) into the down-counter on entry and leaves
    // when the counter reads zero, so it lasts exactly N cycles.
    localparam logic [7:0] SetupLoad  = 8'((SetupCycles  > 0) ? SetupCycles  - 1 : 0);
    localparam logic [7:0] StrobeLoad = 8'((StrobeCycles > 0) ? StrobeCycles - 1 : 0);
    localparam logic [7:0] HoldLoad   = 8'((HoldCycles   > 0) ? HoldCycles   - 1 : 0);
    localparam bit         HasSetup   = (SetupCycles > 0);
    localparam bit         HasHold    = (HoldCycles  > 0);

    localparam logic [FrameSelectWidth-1:0] ColSel   = FrameSelectWidth'(Col);
    localparam logic [FrameSelectWidth-1:0] BcastSel = FrameSelectWidth'(BroadcastSel);

    state_t                       state_q, state_d;
    logic [7:0]                   cnt_q, cnt_d;
    logic [FrameIndexWidth-1:0]   idx_q, idx_d;
    logic [MaxFramesPerCol-1:0]   strobe_q, strobe_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic [MaxFramesPerCol-1:0]   onehot;
    logic                         match;
    logic                         index_bad;
    logic                         accept;

    assign match     = (FrameSelect == ColSel) || (BroadcastEn && (FrameSelect == BcastSel));
    assign index_bad = (int'(FrameIndex) >= MaxFramesPerCol);
    assign accept    = ReqValid && (state_q == IDLE);

    // Next-state, counter and registered-output logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        strobe_d = '0;
        onehot   = '0;

        unique case (state_q)
            IDLE: begin
                // Non-matching beats are consumed with no visible effect.
                if (accept && match) begin
                    if (index_bad) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d = FrameIndex;
                        if (HasSetup) begin
                            state_d = SETUP;
                            cnt_d   = SetupLoad;
                        end else begin
                            state_d = STROBE;
                            cnt_d   = StrobeLoad;
                        end
                    end
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = STROBE;
                    cnt_d   = StrobeLoad;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 8'd0) begin
                    if (HasHold) begin
                        state_d = HOLD;
                        cnt_d   = HoldLoad;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The strobe register follows the state the FSM is entering, so the
        // strobe is high exactly in the STROBE cycles. The index is always
        // below MaxFramesPerCol when latched, so at most one bit is ever set.
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            onehot[i] = (int'(idx_d) == i);
        end
        if (state_d == STROBE) begin
            strobe_d = onehot;
        end
    end

    // An asynchronous reset clears the strobe at once, with no clock edge. It
    // also drops any request in flight, so that request never raises Done.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= '0;
            strobe_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the pre-edge values, independent of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ReqReady      = (state_q == IDLE);
    assign Busy          = (state_q != IDLE);
    assign FrameStrobe_O = strobe_q;
    assign Done          = done_q;
    assign ErrIndex      = err_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_strobe_sequencer
//
// The bench drives four instances from one set of request inputs:
//   [0] Col=18, default timing
//   [1] Col=3,  default timing
//   [2] Col=18, BroadcastEn=0
//   [3] Col=18, SetupCycles=0, StrobeCycles=1, HoldCycles=0
// Cycle c is the interval after the (c-1)th edge. Inputs applied in cycle c
// are taken at the edge that ends cycle c. Outputs are sampled 1 time unit
// after the rising edge.
// ---------------------------------------------------------------------------
module tb_frame_strobe_sequencer;

    localparam int NI    = 4;
    localparam int MAXF  = 20;
    localparam int BCAST = 31;

    logic        CLK;
    logic        resetn;
    logic        ReqValid;
    logic [4:0]  FrameSelect;
    logic [4:0]  FrameIndex;

    logic        ready  [NI];
    logic        busy   [NI];
    logic        done   [NI];
    logic        err    [NI];
    logic [19:0] strobe [NI];

    int n_cmp = 0;
    int n_bad = 0;

    frame_strobe_sequencer #(.Col(18)) dut_a (
        .CLK(CLK), .resetn(resetn), .ReqValid(ReqValid), .ReqReady(ready[0]),
        .FrameSelect(FrameSelect), .FrameIndex(FrameIndex), .FrameStrobe_O(strobe[0]),
        .Busy(busy[0]), .Done(done[0]), .ErrIndex(err[0]));

    frame_strobe_sequencer #(.Col(3)) dut_b (
        .CLK(CLK), .resetn(resetn), .ReqValid(ReqValid), .ReqReady(ready[1]),
        .FrameSelect(FrameSelect), .FrameIndex(FrameIndex), .FrameStrobe_O(strobe[1]),
        .Busy(busy[1]), .Done(done[1]), .ErrIndex(err[1]));

    frame_strobe_sequencer #(.Col(18), .BroadcastEn(1'b0)) dut_c (
        .CLK(CLK), .resetn(resetn), .ReqValid(ReqValid), .ReqReady(ready[2]),
        .FrameSelect(FrameSelect), .FrameIndex(FrameIndex), .FrameStrobe_O(strobe[2]),
        .Busy(busy[2]), .Done(done[2]), .ErrIndex(err[2]));

    frame_strobe_sequencer #(.Col(18), .SetupCycles(0), .StrobeCycles(1), .HoldCycles(0)) dut_f (
        .CLK(CLK), .resetn(resetn), .ReqValid(ReqValid), .ReqReady(ready[3]),
        .FrameSelect(FrameSelect), .FrameIndex(FrameIndex), .FrameStrobe_O(strobe[3]),
        .Busy(busy[3]), .Done(done[3]), .ErrIndex(err[3]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model (request schedule arithmetic) --------
    typedef struct {
        int col; bit be; int s; int t; int h;   // configuration
        int acc;       // cycle whose edge accepted the last good request
        int busy_end;  // last Busy cycle
        int str_beg;   // first strobe cycle
        int str_end;   // last strobe cycle
        int done_at;   // Done cycle
        int err_at;    // ErrIndex cycle
        int idx;       // latched index
    } model_t;

    typedef struct {
        logic [19:0] strobe;
        logic        busy, done, err, ready;
    } outs_t;

    model_t models [NI];

    function automatic model_t model_new(input int col, input bit be, input int s, input int t, input int h);
        model_t m;
        m.col = col; m.be = be; m.s = s; m.t = t; m.h = h;
        m.acc = -100; m.busy_end = -100; m.str_beg = -100; m.str_end = -101;
        m.done_at = -100; m.err_at = -100; m.idx = 0;
        return m;
    endfunction

    function automatic bit model_busy(input model_t m, input int c);
        return (c > m.acc) && (c <= m.busy_end);
    endfunction

    function automatic outs_t model_expect(input model_t m, input int c);
        outs_t o;
        logic [19:0] one;
        one      = 20'd1;
        o.busy   = model_busy(m, c);
        o.ready  = !o.busy;
        o.done   = (c == m.done_at);
        o.err    = (c == m.err_at);
        o.strobe = (c >= m.str_beg && c <= m.str_end) ? (one << m.idx) : 20'd0;
        return o;
    endfunction

    function automatic model_t model_step(input model_t m, input int c, input logic v,
                                          input logic [4:0] sel, input logic [4:0] idx);
        model_t n;
        bit     hit;
        n   = m;
        hit = (int'(sel) == m.col) || (m.be && int'(sel) == BCAST);
        if (v && !model_busy(m, c) && hit) begin
            if (int'(idx) >= MAXF) begin
                n.err_at = c + 1;
            end else begin
                n.acc      = c;
                n.idx      = int'(idx);
                n.str_beg  = c + 1 + m.s;
                n.str_end  = c + m.s + m.t;
                n.busy_end = c + m.s + m.t + m.h;
                n.done_at  = n.busy_end + 1;
            end
        end
        return n;
    endfunction

    // ---------------- helpers ----------------------------------------------
    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        ReqValid    = 1'b0;
        FrameSelect = 5'd0;
        FrameIndex  = 5'd0;
        resetn      = 1'b0;
        repeat (2) tick();
        check("in_reset.strobe", 64'(strobe[0]), 64'd0);
        check("in_reset.busy",   64'(busy[0]),   64'd0);
        resetn = 1'b1;
    endtask

    // ---------------- table-driven latency / broadcast / error vectors -----
    typedef struct {
        logic        valid;
        logic [4:0]  sel;
        logic [4:0]  idx;
        logic [19:0] sa, sb, sc;           // strobe of instances 0,1,2
        logic        busy, done, err, ready; // instance 0
    } vec_t;

    localparam int NROWS = 15;
    vec_t tbl [NROWS];

    initial begin
        resetn      = 1'b0;
        ReqValid    = 1'b0;
        FrameSelect = 5'd0;
        FrameIndex  = 5'd0;

        // Request to col 18, index 7: setup c1, strobe c2-3, hold c4, Done c5.
        tbl[0]  = '{1'b1, 5'd18, 5'd7,  20'h0,   20'h0, 20'h0,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 5'd0,  5'd0,  20'h0,   20'h0, 20'h0,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 5'd0,  5'd0,  20'h80,  20'h0, 20'h80, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 5'd0,  5'd0,  20'h80,  20'h0, 20'h80, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'd0,  5'd0,  20'h0,   20'h0, 20'h0,  1'b1, 1'b0, 1'b0, 1'b0};
        // Done cycle; broadcast index 0 taken here (cols 18 and 3, not BE=0).
        tbl[5]  = '{1'b1, 5'd31, 5'd0,  20'h0,   20'h0, 20'h0,  1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 5'd0,  5'd0,  20'h0,   20'h0, 20'h0,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 5'd0,  5'd0,  20'h1,   20'h1, 20'h0,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 5'd0,  5'd0,  20'h1,   20'h1, 20'h0,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 5'd0,  5'd0,  20'h0,   20'h0, 20'h0,  1'b1, 1'b0, 1'b0, 1'b0};
        // Done; then a non-matching select 17 is consumed silently.
        tbl[10] = '{1'b1, 5'd17, 5'd5,  20'h0,   20'h0, 20'h0,  1'b0, 1'b1, 1'b0, 1'b1};
        // Matching select with out-of-range index 20.
        tbl[11] = '{1'b1, 5'd18, 5'd20, 20'h0,   20'h0, 20'h0,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 5'd0,  5'd0,  20'h0,   20'h0, 20'h0,  1'b0, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 5'd0,  5'd0,  20'h0,   20'h0, 20'h0,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 5'd0,  5'd0,  20'h0,   20'h0, 20'h0,  1'b0, 1'b0, 1'b0, 1'b1};

        do_reset();
        check("reset.ready",  64'(ready[0]),  64'd1);
        check("reset.done",   64'(done[0]),   64'd0);
        check("reset.err",    64'(err[0]),    64'd0);

        for (int r = 0; r < NROWS; r++) begin
            ReqValid    = tbl[r].valid;
            FrameSelect = tbl[r].sel;
            FrameIndex  = tbl[r].idx;
            check($sformatf("tbl%0d.strobe_a", r), 64'(strobe[0]), 64'(tbl[r].sa));
            check($sformatf("tbl%0d.strobe_b", r), 64'(strobe[1]), 64'(tbl[r].sb));
            check($sformatf("tbl%0d.strobe_c", r), 64'(strobe[2]), 64'(tbl[r].sc));
            check($sformatf("tbl%0d.busy", r),     64'(busy[0]),   64'(tbl[r].busy));
            check($sformatf("tbl%0d.done", r),     64'(done[0]),   64'(tbl[r].done));
            check($sformatf("tbl%0d.err", r),      64'(err[0]),    64'(tbl[r].err));
            check($sformatf("tbl%0d.ready", r),    64'(ready[0]),  64'(tbl[r].ready));
            tick();
        end

        // ---------------- reset asserted while strobing ---------------------
        do_reset();
        ReqValid = 1'b1; FrameSelect = 5'd18; FrameIndex = 5'd9;
        tick();                       // cycle 1: SETUP
        ReqValid = 1'b0;
        tick();                       // cycle 2: STROBE
        check("abort.strobe_before", 64'(strobe[0]), 64'h200);
        #1 resetn = 1'b0;
        #1;
        check("abort.strobe_async", 64'(strobe[0]), 64'd0);
        check("abort.busy_async",   64'(busy[0]),   64'd0);
        #1 resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("abort.no_done%0d", k),   64'(done[0]),   64'd0);
            check($sformatf("abort.no_strobe%0d", k), 64'(strobe[0]), 64'd0);
        end

        // ---------------- back-to-back with zero setup/hold ------------------
        do_reset();
        ReqValid = 1'b1; FrameSelect = 5'd18; FrameIndex = 5'd4;
        check("b2b.c0_ready", 64'(ready[3]), 64'd1);
        tick();                       // cycle 1
        FrameIndex = 5'd19;
        check("b2b.c1_strobe", 64'(strobe[3]), 64'h10);
        check("b2b.c1_busy",   64'(busy[3]),   64'd1);
        check("b2b.c1_done",   64'(done[3]),   64'd0);
        tick();                       // cycle 2: Done, second accept
        check("b2b.c2_strobe", 64'(strobe[3]), 64'd0);
        check("b2b.c2_done",   64'(done[3]),   64'd1);
        check("b2b.c2_ready",  64'(ready[3]),  64'd1);
        tick();                       // cycle 3
        ReqValid = 1'b0;
        check("b2b.c3_strobe", 64'(strobe[3]), 64'h80000);
        check("b2b.c3_busy",   64'(busy[3]),   64'd1);
        tick();                       // cycle 4
        check("b2b.c4_done",   64'(done[3]),   64'd1);
        check("b2b.c4_strobe", 64'(strobe[3]), 64'd0);

        // ---------------- randomized against the schedule model -------------
        do_reset();
        models[0] = model_new(18, 1'b1, 1, 2, 1);
        models[1] = model_new(3,  1'b1, 1, 2, 1);
        models[2] = model_new(18, 1'b0, 1, 2, 1);
        models[3] = model_new(18, 1'b1, 0, 1, 0);
        for (int c = 0; c < 800; c++) begin
            outs_t e;
            ReqValid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0:       FrameSelect = 5'd18;
                1:       FrameSelect = 5'd3;
                2:       FrameSelect = 5'd31;
                3:       FrameSelect = 5'd17;
                default: FrameSelect = 5'($urandom_range(0, 31));
            endcase
            FrameIndex = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(20, 31))
                                                     : 5'($urandom_range(0, 19));
            for (int i = 0; i < NI; i++) begin
                e = model_expect(models[i], c);
                check($sformatf("rnd%0d.%0d.strobe", c, i), 64'(strobe[i]), 64'(e.strobe));
                check($sformatf("rnd%0d.%0d.busy", c, i),   64'(busy[i]),   64'(e.busy));
                check($sformatf("rnd%0d.%0d.ready", c, i),  64'(ready[i]),  64'(e.ready));
                check($sformatf("rnd%0d.%0d.done", c, i),   64'(done[i]),   64'(e.done));
                check($sformatf("rnd%0d.%0d.err", c, i),    64'(err[i]),    64'(e.err));
                models[i] = model_step(models[i], c, ReqValid, FrameSelect, FrameIndex);
            end
            tick();
        end
        ReqValid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
